// File: rtl/rtlola_sched_pkg.sv
// Shared types and default parameters for the RTLola evaluation scheduler.
package rtlola_sched_pkg;
  localparam int DEF_NUM_INPUTS    = 3;
  localparam int DEF_NUM_LAYERS    = 4;
  localparam int DEF_QUEUE_DEPTH   = 4;
  localparam int DEF_PERIOD_CYCLES = 500;
  localparam int DEF_TS_WIDTH      = 32;
  localparam int DEF_PTR_W         = $clog2(DEF_QUEUE_DEPTH);

  typedef struct packed {
    logic [DEF_NUM_INPUTS-1:0] mask;
    logic                      periodic;
    logic [DEF_TS_WIDTH-1:0]   ts;
  } sched_event_t;
endpackage

// File: rtl/rtlola_eval_scheduler_fifo.sv
// Power-of-two event queue with simultaneous push/pop and no fall-through.
module event_fifo
  import rtlola_sched_pkg::*;
#(
  parameter int DEPTH = DEF_QUEUE_DEPTH,
  parameter int WIDTH = $bits(sched_event_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rtlola_eval_scheduler.sv
// Merges input arrivals and periodic deadlines into timestamped events, queues
// them, and issues at most one per cycle into a shifting layer-enable pipeline.
module rtlola_eval_scheduler
  import rtlola_sched_pkg::*;
#(
  parameter int NUM_INPUTS    = DEF_NUM_INPUTS,
  parameter int NUM_LAYERS    = DEF_NUM_LAYERS,
  parameter int QUEUE_DEPTH   = DEF_QUEUE_DEPTH,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int TS_WIDTH      = DEF_TS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_INPUTS-1:0]        new_input,
  input  logic                         hold,
  output logic                         q_push,
  output logic                         q_push_valid,
  output logic                         q_pop,
  output logic                         q_pop_valid,
  output logic [NUM_LAYERS:0]          layer_en,
  output logic [NUM_INPUTS-1:0]        ev_mask,
  output logic [TS_WIDTH-1:0]          ev_ts,
  output logic                         slide,
  output logic                         overflow,
  output logic [$clog2(QUEUE_DEPTH):0] q_count
);
  localparam int EV_W  = NUM_INPUTS + 1 + TS_WIDTH;
  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(PERIOD_CYCLES - 1);

  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ts_next;
  logic [PER_W-1:0]    per_cnt;
  logic                deadline;
  logic                form;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;
  logic [EV_W-1:0]     ev_in;
  logic [EV_W-1:0]     ev_head;

  // An event is stamped with the count of enabled edges including its own.
  assign ts_next  = ts + 1'b1;
  assign deadline = (per_cnt == '0);
  assign form     = en && ((|new_input) || deadline);
  assign pop      = en && !hold && !empty;
  assign push     = form && (!full || pop);
  assign ev_in    = {new_input, deadline, ts_next};

  event_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (ev_head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts           <= '0;
      per_cnt      <= PER_RELOAD;
      q_push       <= 1'b0;
      q_push_valid <= 1'b0;
      q_pop        <= 1'b0;
      q_pop_valid  <= 1'b0;
      layer_en     <= '0;
      ev_mask      <= '0;
      ev_ts        <= '0;
      slide        <= 1'b0;
      overflow     <= 1'b0;
    end else if (en) begin
      ts           <= ts_next;
      per_cnt      <= deadline ? PER_RELOAD : per_cnt - 1'b1;
      q_push       <= form;
      q_push_valid <= push;
      q_pop        <= pop;
      q_pop_valid  <= pop;
      layer_en     <= {layer_en[NUM_LAYERS-1:0], pop};
      if (form && !push) overflow <= 1'b1;
      if (pop) {ev_mask, slide, ev_ts} <= ev_head;
      else     {ev_mask, slide, ev_ts} <= '0;
    end
  end
endmodule

// File: doc/rtlola_eval_scheduler.md
# rtlola_eval_scheduler

Event scheduler for the monitor's tight evaluation pipeline. Each cycle it merges input-arrival flags and an internal periodic deadline into one timestamped event, buffers events in a small queue, and issues at most one event per cycle into a shifting layer-enable pipeline. The shifting pipeline drives the per-layer evaluation enables, the window-slide strobe and the queue push/pop status observed by the testbenches.

## Interface
- `NUM_INPUTS`, default 3: number of input streams.
- `NUM_LAYERS`, default 4: output evaluation layers after the input layer (layer 0).
- `QUEUE_DEPTH`, default 4: event queue entries, a power of two, minimum 2.
- `PERIOD_CYCLES`, default 500: clock cycles between periodic deadlines, minimum 2.
- `TS_WIDTH`, default 32: timestamp width in cycles.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state.
- `new_input`  in  NUM_INPUTS  per-stream arrival flags, one-cycle pulses.
- `hold`  in  1  downstream busy; blocks pops.
- `q_push`  out  1  event formed last cycle.
- `q_push_valid`  out  1  that event was accepted into the queue.
- `q_pop`  out  1  an event entered layer 0 this cycle.
- `q_pop_valid`  out  1  equal to `q_pop`; the pop was legal.
- `layer_en`  out  NUM_LAYERS+1  per-layer evaluate strobe.
- `ev_mask`  out  NUM_INPUTS  input mask of the event in layer 0.
- `ev_ts`  out  TS_WIDTH  timestamp of the event in layer 0.
- `slide`  out  1  the layer-0 event carries a periodic deadline.
- `overflow`  out  1  sticky flag; an event was dropped.
- `q_count`  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.

## Operation
- `ts` is a free-running cycle counter that advances on every enabled edge and wraps modulo 2^TS_WIDTH.
- `per_cnt` counts down from PERIOD_CYCLES-1. A deadline occurs on the edge where `per_cnt`==0, and the counter then reloads.
- **Event formation:** on each enabled edge, if `new_input`!=0 or a deadline occurs, form event {mask=new_input, periodic=deadline, ts}.
  - An input arrival and a deadline in the same cycle merge into a single event.
- **Push:** the event is written if the queue is not full, or if a pop happens on the same edge (pop frees the slot first).
  - Otherwise the event is dropped: `q_push_valid`=0 and `overflow` is set until reset.
- **Pop:** on each enabled edge with `hold`=0 and the queue non-empty before this edge's push, the head moves into stage 0.
  - There is no empty-queue bypass.
- **Pipeline:** NUM_LAYERS+1 valid/periodic stages that shift every enabled edge, with bubbles inserted when there is no pop.
  - `layer_en[k]` = stage k valid.
  - `ev_mask`, `ev_ts` and `slide` are taken from stage 0 and are zero when stage 0 is empty.
- **`en`=0:** nothing advances (ts, per_cnt, queue, pipeline); `new_input` is ignored; outputs hold their values.
- **Reset:** all outputs 0, queue empty, ts=0, per_cnt=PERIOD_CYCLES-1, pipeline empty.
  - Reset mid-operation discards queued and in-flight events immediately and asynchronously.

## Timing
- All outputs are registered; no output has a combinational path from an input.
- Event sampled at edge E:
  - `q_push` and `q_push_valid` are high during cycle E..E+1, with the entry written at E.
  - The earliest pop is at edge E+1: `q_pop` and `layer_en[0]` are high during E+1..E+2.
  - `layer_en[k]` is high during E+1+k..E+2+k.
- Latency from input flag to last layer: NUM_LAYERS+2 edges, with one event issued per cycle in steady state.
- `hold` is sampled at the pop edge. An event blocked by `hold` waits without loss while the queue has room.
- The first deadline occurs at the PERIOD_CYCLES-th enabled edge after reset release.
- `ts` wrap is silent; ordering is by queue position, not by ts.

## Structure
- Package `rtlola_sched_pkg` contains:
  - `sched_event_t` struct {mask, periodic, ts};
  - default parameter constants;
  - the `clog2`-derived pointer width.
- Sub-module `event_fifo`:
  - parameterized depth and width;
  - simultaneous push and pop;
  - full, empty and count outputs;
  - no fall-through.
- The top level holds the timestamp counter, the periodic counter, push/drop logic and the layer shift register.

## Test plan
- **Single input:** `new_input`=3'b001 at edge 10 -> `q_push`=`q_push_valid`=1 in cycle 10; `layer_en[0]`=1 with ev_mask=001 and ev_ts=10 in cycle 11; `layer_en[4]`=1 in cycle 15.
- **Merge:** `new_input`=3'b110 at edge 500 (the first deadline) -> one event, mask=110, `slide`=1 in cycle 501; exactly one push.
- **Back-to-back:** flags on 4 consecutive edges with `hold`=0 -> 4 consecutive `layer_en[0]` pulses with ts values n..n+3; `q_count` never exceeds 1.
- **Overflow:** `hold`=1 and flags on 6 consecutive edges -> first 4 accepted, pushes 5 and 6 have `q_push_valid`=0, `overflow`=1. Release `hold` -> 4 pops in order.
- **Full with simultaneous pop:** queue full, `hold` falls and a flag arrives on the same edge -> push accepted, `q_count` stays 4, `overflow` unchanged.
- **Reset mid-flight:** `rst`=0 while 3 events are queued and 2 are in the pipeline -> all outputs 0 immediately. After release, no stale `layer_en` appears and the first deadline arrives at edge 500 after release.
